// File: rtl/vector_serializer_if.sv
// vector_serializer_if: vector-in / element-out handshake bundle.
// master drives vectors and takes elements; slave is the serializer.
interface vector_serializer_if #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;

  logic                        in_valid;
  logic                        in_ready;
  logic [DEPTH-1:0][WIDTH-1:0] in;
  logic                        out_valid;
  logic                        out_ready;
  logic [WIDTH-1:0]            out;
  logic [IDX_W-1:0]            out_index;
  logic                        out_last;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, out_index, out_last
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, out_index, out_last
  );
endinterface

// File: rtl/vector_serializer.sv
// vector_serializer: parallel-in, serial-out, oldest tap first.
// Gapless vector handoff on the last beat; en freezes everything.
module vector_serializer #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  vector_serializer_if.slave bus
);
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;

  typedef enum logic {
    EMPTY,
    BUSY
  } state_t;

  state_t                      state;
  state_t                      state_d;
  logic [DEPTH-1:0][WIDTH-1:0] vec;
  logic [WIDTH-1:0]            out_q;
  logic [IDX_W-1:0]            idx;
  logic [IDX_W-1:0]            idx_m1;
  logic                        last_q;
  logic                        in_xfer;
  logic                        out_xfer;
  logic                        load;
  logic                        step;

  assign bus.out_valid = (state == BUSY);
  assign bus.out       = out_q;
  assign bus.out_index = idx;
  assign bus.out_last  = last_q;

  assign bus.in_ready = rst && en &&
    (state == EMPTY ||
     (bus.out_valid && bus.out_ready && last_q));

  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = en && bus.out_valid && bus.out_ready;
  assign idx_m1   = idx - 1'b1;

  // Next state and datapath load/step selection.
  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_d = BUSY;
          load    = 1'b1;
        end
      end
      BUSY: begin
        if (out_xfer) begin
          if (!last_q) begin
            step = 1'b1;
          end else if (in_xfer) begin
            load = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: ;
    endcase
  end

  // State register; reset wins over any transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_d;
    end
  end

  // Vector buffer and registered output element.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vec    <= '0;
      out_q  <= '0;
      idx    <= '0;
      last_q <= 1'b0;
    end else if (load) begin
      vec    <= bus.in;
      out_q  <= bus.in[DEPTH-1];
      idx    <= IDX_W'(DEPTH - 1);
      last_q <= (DEPTH == 1);
    end else if (step) begin
      out_q  <= vec[idx_m1];
      idx    <= idx_m1;
      last_q <= (idx_m1 == '0);
    end
  end
endmodule

// File: tb/tb_vector_serializer.sv
// tb_vector_serializer: scoreboard bench for vector_serializer.
// DEPTH=4 directed scenarios plus DEPTH=1/5 random round trips.
module tb_vector_serializer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en4;
  logic ven[2];

  vector_serializer_if #(.WIDTH(8), .DEPTH(4)) b4 ();
  vector_serializer_if #(.WIDTH(8), .DEPTH(1)) b1 ();
  vector_serializer_if #(.WIDTH(8), .DEPTH(5)) b5 ();

  vector_serializer #(.WIDTH(8), .DEPTH(4)) u4 (
    .clk(clk), .rst(rst), .en(en4), .bus(b4)
  );
  vector_serializer #(.WIDTH(8), .DEPTH(1)) u1 (
    .clk(clk), .rst(rst), .en(ven[0]), .bus(b1)
  );
  vector_serializer #(.WIDTH(8), .DEPTH(5)) u5 (
    .clk(clk), .rst(rst), .en(ven[1]), .bus(b5)
  );

  logic            vin_valid[2];
  logic [4:0][7:0] vin[2];
  logic            vordy[2];
  logic            vir[2];
  logic            vov[2];
  logic [7:0]      vout[2];
  logic [2:0]      vidx[2];
  logic            vlast[2];

  assign b1.in_valid  = vin_valid[0];
  assign b1.in        = vin[0][0];
  assign b1.out_ready = vordy[0];
  assign b5.in_valid  = vin_valid[1];
  assign b5.in        = vin[1];
  assign b5.out_ready = vordy[1];
  assign vir[0]   = b1.in_ready;
  assign vov[0]   = b1.out_valid;
  assign vout[0]  = b1.out;
  assign vidx[0]  = {2'b00, b1.out_index};
  assign vlast[0] = b1.out_last;
  assign vir[1]   = b5.in_ready;
  assign vov[1]   = b5.out_valid;
  assign vout[1]  = b5.out;
  assign vidx[1]  = b5.out_index;
  assign vlast[1] = b5.out_last;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] i;
    logic       l;
  } beat_t;

  beat_t q4[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    checks = 0;

  // Expected beat k of a vector is element DEPTH-1-k.
  function automatic void push4(input logic [3:0][7:0] v);
    for (int k = 0; k < 4; k++) begin
      q4.push_back('{d: v[3-k], i: 2'(3 - k), l: (k == 3)});
    end
    vectors++;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    b4.in_valid = 1'b1;
    b4.in = 32'($urandom());
    b4.out_ready = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    checks++;
    if ({b4.out_valid, b4.out, b4.out_index, b4.out_last, b4.in_ready}
        !== 13'd0) begin
      miscompares++;
      $display("FAIL reset.outputs: got v=%b d=%h i=%0d l=%b r=%b, expected all 0",
               b4.out_valid, b4.out, b4.out_index, b4.out_last, b4.in_ready);
    end
    cyc();
    rst = 1'b1;
    b4.in_valid = 1'b0;
    cyc();
    @(negedge clk);
    checks++;
    if (b4.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset.in_ready: got %b, expected 1", b4.in_ready);
    end
    cyc();
  endtask

  task automatic test_single();
    logic exp_ir, ix, ox;
    int beats = 0;
    b4.in = {8'h44, 8'h33, 8'h22, 8'h11};
    b4.in_valid = 1'b1;
    b4.out_ready = 1'b1;
    en4 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_ir = rst && en4 &&
        (q4.size() == 0 || (b4.out_ready && q4[0].l));
      checks++;
      if (b4.in_ready !== exp_ir) begin
        miscompares++;
        $display("FAIL single.in_ready c%0d: got %b, expected %b", c, b4.in_ready, exp_ir);
      end
      checks++;
      if (b4.out_valid !== (q4.size() != 0)) begin
        miscompares++;
        $display("FAIL single.out_valid c%0d: got %b, expected %b", c, b4.out_valid, q4.size() != 0);
      end
      if (q4.size() != 0) begin
        checks++;
        if ({b4.out, b4.out_index, b4.out_last} !== q4[0]) begin
          miscompares++;
          $display("FAIL single.beat c%0d: got %h, expected %h", c, {b4.out, b4.out_index, b4.out_last}, q4[0]);
        end
      end
      ix = b4.in_valid && exp_ir;
      ox = rst && en4 && b4.out_ready && q4.size() != 0;
      cyc();
      if (ox) begin
        void'(q4.pop_front());
        beats++;
      end
      if (ix) begin
        push4(b4.in);
        b4.in_valid = 1'b0;
      end
    end
    checks++;
    if (beats != 4) begin
      miscompares++;
      $display("FAIL single.count: got %0d beats, expected 4", beats);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ir, ix, ox;
    logic [3:0][7:0] va, vb;
    int beats = 0, first_c = -1, last_c = -1, sent = 0;
    va = 32'($urandom());
    vb = 32'($urandom());
    b4.in = va;
    b4.in_valid = 1'b1;
    b4.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_ir = rst && en4 &&
        (q4.size() == 0 || (b4.out_ready && q4[0].l));
      checks++;
      if (b4.in_ready !== exp_ir) begin
        miscompares++;
        $display("FAIL b2b.in_ready c%0d: got %b, expected %b", c, b4.in_ready, exp_ir);
      end
      checks++;
      if (b4.out_valid !== (q4.size() != 0)) begin
        miscompares++;
        $display("FAIL b2b.out_valid c%0d: got %b, expected %b", c, b4.out_valid, q4.size() != 0);
      end
      if (q4.size() != 0) begin
        checks++;
        if ({b4.out, b4.out_index, b4.out_last} !== q4[0]) begin
          miscompares++;
          $display("FAIL b2b.beat c%0d: got %h, expected %h", c, {b4.out, b4.out_index, b4.out_last}, q4[0]);
        end
      end
      ix = b4.in_valid && exp_ir;
      ox = rst && en4 && b4.out_ready && q4.size() != 0;
      if (ox) begin
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      cyc();
      if (ox) begin
        void'(q4.pop_front());
        beats++;
      end
      if (ix) begin
        push4(b4.in);
        sent++;
        if (sent == 1) b4.in = vb;
        else b4.in_valid = 1'b0;
      end
    end
    checks++;
    if (beats != 8 || last_c - first_c != 7) begin
      miscompares++;
      $display("FAIL b2b.gapless: got %0d beats over %0d cycles, expected 8 over 8",
               beats, last_c - first_c + 1);
    end
  endtask

  task automatic test_backpressure_stall();
    logic exp_ir, ix, ox;
    int beats = 0, bp = 0, st = 0;
    b4.in = {8'h44, 8'h33, 8'h22, 8'h11};
    b4.in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      b4.out_ready = 1'b1;
      en4 = 1'b1;
      if (q4.size() != 0 && q4[0].d == 8'h33 && bp < 3) begin
        b4.out_ready = 1'b0;
        bp++;
      end
      if (q4.size() != 0 && q4[0].d == 8'h22 && st < 2) begin
        en4 = 1'b0;
        st++;
      end
      @(negedge clk);
      exp_ir = rst && en4 &&
        (q4.size() == 0 || (b4.out_ready && q4[0].l));
      checks++;
      if (b4.in_ready !== exp_ir) begin
        miscompares++;
        $display("FAIL stall.in_ready c%0d: got %b, expected %b", c, b4.in_ready, exp_ir);
      end
      checks++;
      if (b4.out_valid !== (q4.size() != 0)) begin
        miscompares++;
        $display("FAIL stall.out_valid c%0d: got %b, expected %b", c, b4.out_valid, q4.size() != 0);
      end
      if (q4.size() != 0) begin
        checks++;
        if ({b4.out, b4.out_index, b4.out_last} !== q4[0]) begin
          miscompares++;
          $display("FAIL stall.beat c%0d: got %h, expected %h", c, {b4.out, b4.out_index, b4.out_last}, q4[0]);
        end
      end
      ix = b4.in_valid && exp_ir;
      ox = rst && en4 && b4.out_ready && q4.size() != 0;
      cyc();
      if (ox) begin
        void'(q4.pop_front());
        beats++;
      end
      if (ix) begin
        push4(b4.in);
        b4.in_valid = 1'b0;
      end
    end
    en4 = 1'b1;
    b4.out_ready = 1'b1;
    checks++;
    if (beats != 4 || bp != 3 || st != 2) begin
      miscompares++;
      $display("FAIL stall.count: got %0d beats (bp %0d, stall %0d), expected 4 (3, 2)",
               beats, bp, st);
    end
  endtask

  task automatic test_reset_mid_vector();
    logic exp_ir, ix, ox;
    int beats = 0;
    bit did = 0, sent2 = 0, was_rst = 0;
    b4.in = {8'h44, 8'h33, 8'h22, 8'h11};
    b4.in_valid = 1'b1;
    b4.out_ready = 1'b1;
    en4 = 1'b1;
    for (int c = 0; c < 14; c++) begin
      rst = 1'b1;
      if (beats == 2 && !did) begin
        rst = 1'b0;
        did = 1;
      end
      if (did && rst && !sent2 && q4.size() == 0) begin
        b4.in = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        b4.in_valid = 1'b1;
        sent2 = 1;
      end
      @(negedge clk);
      exp_ir = rst && en4 &&
        (q4.size() == 0 || (b4.out_ready && q4[0].l));
      checks++;
      if (b4.in_ready !== exp_ir) begin
        miscompares++;
        $display("FAIL midrst.in_ready c%0d: got %b, expected %b", c, b4.in_ready, exp_ir);
      end
      checks++;
      if (b4.out_valid !== (q4.size() != 0)) begin
        miscompares++;
        $display("FAIL midrst.out_valid c%0d: got %b, expected %b", c, b4.out_valid, q4.size() != 0);
      end
      if (was_rst) begin
        checks++;
        if (b4.out !== 8'h00) begin
          miscompares++;
          $display("FAIL midrst.out_cleared: got %h, expected 00", b4.out);
        end
      end
      if (q4.size() != 0) begin
        checks++;
        if ({b4.out, b4.out_index, b4.out_last} !== q4[0]) begin
          miscompares++;
          $display("FAIL midrst.beat c%0d: got %h, expected %h", c, {b4.out, b4.out_index, b4.out_last}, q4[0]);
        end
      end
      ix = b4.in_valid && exp_ir;
      ox = rst && en4 && b4.out_ready && q4.size() != 0;
      was_rst = !rst;
      cyc();
      if (!rst) q4.delete();
      if (ox) begin
        void'(q4.pop_front());
        beats++;
      end
      if (ix) begin
        push4(b4.in);
        b4.in_valid = 1'b0;
      end
    end
    rst = 1'b1;
    checks++;
    if (beats != 6) begin
      miscompares++;
      $display("FAIL midrst.count: got %0d beats, expected 6", beats);
    end
  endtask

  task automatic test_round_trip();
    logic [4:0][7:0] rq0[$];
    logic [4:0][7:0] rq1[$];
    logic [4:0][7:0] front, tv, fm;
    logic [7:0] tap[2][5];
    logic [7:0] cap[2];
    logic [7:0] ed;
    logic [2:0] ei;
    logic el, busy, exp_ir;
    logic ix[2], ox[2];
    int kk[2];
    int dep;
    kk = '{0, 0};
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 5; i++) tap[d][i] = '0;
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        vin_valid[d] = ($urandom_range(0, 3) != 0);
        vin[d] = 40'({$urandom(), $urandom()});
        vordy[d] = ($urandom_range(0, 3) != 0);
        ven[d] = ($urandom_range(0, 7) != 0);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        dep = (d == 0) ? 1 : 5;
        busy = (d == 0) ? (rq0.size() != 0) : (rq1.size() != 0);
        front = '0;
        if (busy) front = (d == 0) ? rq0[0] : rq1[0];
        exp_ir = ven[d] && (!busy || (vordy[d] && kk[d] == dep - 1));
        checks++;
        if (vir[d] !== exp_ir) begin
          miscompares++;
          $display("FAIL rt%0d.in_ready c%0d: got %b, expected %b", dep, c, vir[d], exp_ir);
        end
        checks++;
        if (vov[d] !== busy) begin
          miscompares++;
          $display("FAIL rt%0d.out_valid c%0d: got %b, expected %b", dep, c, vov[d], busy);
        end
        if (busy) begin
          ed = front[dep-1-kk[d]];
          ei = 3'(dep - 1 - kk[d]);
          el = (kk[d] == dep - 1);
          checks++;
          if ({vout[d], vidx[d], vlast[d]} !== {ed, ei, el}) begin
            miscompares++;
            $display("FAIL rt%0d.beat c%0d: got d=%h i=%0d l=%b, expected d=%h i=%0d l=%b",
                     dep, c, vout[d], vidx[d], vlast[d], ed, ei, el);
          end
        end
        ix[d] = vin_valid[d] && exp_ir;
        ox[d] = ven[d] && busy && vordy[d];
        cap[d] = vout[d];
      end
      cyc();
      for (int d = 0; d < 2; d++) begin
        dep = (d == 0) ? 1 : 5;
        if (ox[d]) begin
          for (int i = 4; i > 0; i--) tap[d][i] = tap[d][i-1];
          tap[d][0] = cap[d];
          kk[d]++;
          if (kk[d] == dep) begin
            if (d == 0) front = rq0.pop_front();
            else front = rq1.pop_front();
            kk[d] = 0;
            tv = '0;
            fm = '0;
            for (int i = 0; i < dep; i++) begin
              tv[i] = tap[d][i];
              fm[i] = front[i];
            end
            checks++;
            if (tv !== fm) begin
              miscompares++;
              $display("FAIL rt%0d.taps c%0d: got %h, expected %h", dep, c, tv, fm);
            end
          end
        end
        if (ix[d]) begin
          if (d == 0) rq0.push_back(vin[d]);
          else rq1.push_back(vin[d]);
          vectors++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    en4 = 1'b1;
    ven[0] = 1'b1;
    ven[1] = 1'b1;
    b4.in_valid = 1'b0;
    b4.in = '0;
    b4.out_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      vin_valid[d] = 1'b0;
      vin[d] = '0;
      vordy[d] = 1'b0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure_stall();
    test_reset_mid_vector();
    test_round_trip();
    if (checks < 12) begin
      miscompares++;
      $display("FAIL bench.coverage: got %0d comparisons, expected at least 12", checks);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
